alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor of the team's combinational ALU.
- Uses the same operation encoding and adds a valid/ready handshake on both sides, registered status flags, an error flag for invalid codes, and defined behaviour for out-of-range shift amounts.
- Sits between the operand/opcode source and the result sink. Either side may stall.

Parameters:
- BITS_DATA, 8, operand and result width (>=4).
- BITS_OP, 6, operation code width (encodings below occupy 6 LSBs; upper bits must be 0 for a valid code).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input operands/op valid.
- o_ready  out  1  block can accept input this cycle.
- i_a  in  BITS_DATA  signed operand A.
- i_b  in  BITS_DATA  signed operand B; shift amount (unsigned) for shifts.
- i_op  in  BITS_OP  operation code.
- o_valid  out  1  result valid.
- i_ready  in  1  sink accepts result this cycle.
- o_result  out  BITS_DATA  signed result.
- o_zero  out  1  result == 0.
- o_neg  out  1  result MSB.
- o_carry  out  1  ADD: unsigned carry-out; SUB: unsigned borrow (A<B); else 0.
- o_ovf  out  1  signed overflow for ADD/SUB; else 0.
- o_err  out  1  op code not in the table; result forced 0.

Behaviour:
- Op codes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRL 000010: logical right shift, zero fill.
  - SRA 000011: arithmetic right shift, sign fill.
- Shift amount is i_b read as unsigned.
  - If amount >= BITS_DATA: SRL yields 0; SRA yields all copies of A's MSB.
- Stage 1 (S1): input register, capturing a, b, op and valid.
- Stage 2 (S2): compute from S1 contents; register result, flags and valid. o_* are driven directly from S2 registers.
- Latency: an accepted input appears on o_valid exactly 2 cycles later when no stall occurs. Throughput is 1 per cycle.
- Transfers:
  - Input transfer on i_valid & o_ready.
  - Output transfer on o_valid & i_ready.
- Advance rules:
  - s2_adv = ~s2_valid | i_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - o_ready = s1_adv (combinational path from i_ready permitted).
- Stall: while o_valid=1 and i_ready=0, o_result and all flags stay stable. S1 holds its contents, and o_ready drops once S1 is occupied.
- Ordering is strictly preserved. No result is dropped or duplicated.
- Simultaneous empty and fill of a stage in one cycle is allowed (full throughput under i_ready=1).
- Flags are computed on the final result (after saturation when enabled). o_zero and o_neg are valid for all ops, including an error result (zero=1, neg=0).
- Reset, including mid-operation:
  - s1_valid and s2_valid clear to 0 and o_valid=0 on the next edge; in-flight ops are discarded.
  - o_result=0, o_zero=0, o_neg=0, o_carry=0, o_ovf=0, o_err=0.
  - o_ready=1 after reset.
- Data registers may update when valid=0. Outputs other than o_valid are don't-care while o_valid=0, except immediately after reset as above.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- Defined:
  - ADD and SUB saturate on signed overflow: positive overflow gives 0111..1, negative overflow gives 1000..0.
  - o_ovf still reports that overflow occurred.
  - o_carry is unchanged (computed on the raw unsigned operation).
- Undefined: ADD and SUB wrap modulo 2^BITS_DATA.

Test Plan:
1. ADD a=0x7F, b=0x01, i_ready=1:
   - without macro: result 0x80, ovf=1, neg=1, carry=0, zero=0, appearing 2 cycles after accept.
   - with ALU_PIPE_SAT_EN: result 0x7F, ovf=1.
2. SUB a=0x00, b=0x01 -> result 0xFF, carry=1, ovf=0, neg=1. SUB a=0x05, b=0x05 -> result 0x00, zero=1, carry=0.
3. Shifts, a=0x80:
   - SRA b=3 -> 0xF0; SRL b=3 -> 0x10.
   - SRA b=9 -> 0xFF; SRL b=9 -> 0x00.
   - SRA a=0x40, b=8 -> 0x00.
4. Invalid op 0x3F with a=0x12, b=0x34 -> result 0x00, err=1, zero=1. The next valid op, AND 0xF0 & 0x3C, gives 0x30, err=0.
5. Backpressure and ordering:
   - Issue 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4) with i_ready=0 for cycles 0-5.
   - o_ready drops after 2 accepts and o_result holds 0x02 stable.
   - After i_ready=1, outputs are 0x02, 0x04, 0x06, 0x08 in order, with no gaps once streaming.
6. Reset mid-operation: accept 2 ops, assert i_reset for 1 cycle while both stages are full. On the next cycle o_valid=0, all flags 0, o_ready=1, and no stale result ever appears afterwards.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready handshake bundle for alu_pipe.
//   Request side : i_valid, o_ready, i_a, i_b, i_op
//   Response side: o_valid, i_ready, o_result, o_zero, o_neg, o_carry,
//                  o_ovf, o_err
//   modport slave  - the ALU pipeline
//   modport master - the operand source / result sink
interface alu_pipe_if #(
   parameter int BITS_DATA = 8,
   parameter int BITS_OP   = 6
);
   logic                 i_valid;
   logic                 o_ready;
   logic [BITS_DATA-1:0] i_a;
   logic [BITS_DATA-1:0] i_b;
   logic [BITS_OP-1:0]   i_op;
   logic                 o_valid;
   logic                 i_ready;
   logic [BITS_DATA-1:0] o_result;
   logic                 o_zero;
   logic                 o_neg;
   logic                 o_carry;
   logic                 o_ovf;
   logic                 o_err;

   modport slave (
      input  i_valid, i_a, i_b, i_op, i_ready,
      output o_ready, o_valid, o_result, o_zero, o_neg, o_carry, o_ovf, o_err
   );

   modport master (
      output i_valid, i_a, i_b, i_op, i_ready,
      input  o_ready, o_valid, o_result, o_zero, o_neg, o_carry, o_ovf, o_err
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   S1 registers the operands/op, S2 registers the result and flags;
//   all bus outputs come straight from S2 registers.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - synchronous active-high reset
//   bus     - alu_pipe_if.slave (operands, op, result, flags, handshake)
// Optional feature macro: ALU_PIPE_SAT_EN
//   defined   - ADD/SUB saturate on signed overflow (o_ovf still set)
//   undefined - ADD/SUB wrap
module alu_pipe #(
   parameter int BITS_DATA = 8,
   parameter int BITS_OP   = 6
) (
   input logic       i_clk,
   input logic       i_reset,
   alu_pipe_if.slave bus
);
   localparam int MSB = BITS_DATA - 1;

   localparam logic [BITS_OP-1:0] LP_OP_ADD = BITS_OP'(6'b100000);
   localparam logic [BITS_OP-1:0] LP_OP_SUB = BITS_OP'(6'b100010);
   localparam logic [BITS_OP-1:0] LP_OP_AND = BITS_OP'(6'b100100);
   localparam logic [BITS_OP-1:0] LP_OP_OR  = BITS_OP'(6'b100101);
   localparam logic [BITS_OP-1:0] LP_OP_XOR = BITS_OP'(6'b100110);
   localparam logic [BITS_OP-1:0] LP_OP_NOR = BITS_OP'(6'b100111);
   localparam logic [BITS_OP-1:0] LP_OP_SRL = BITS_OP'(6'b000010);
   localparam logic [BITS_OP-1:0] LP_OP_SRA = BITS_OP'(6'b000011);

   localparam logic [BITS_DATA-1:0] LP_WIDTH = BITS_DATA'(BITS_DATA);
`ifdef ALU_PIPE_SAT_EN
   localparam logic [BITS_DATA-1:0] LP_SMAX = {1'b0, {(BITS_DATA-1){1'b1}}};
   localparam logic [BITS_DATA-1:0] LP_SMIN = {1'b1, {(BITS_DATA-1){1'b0}}};
`endif

   logic                 r_s1_valid;
   logic [BITS_DATA-1:0] r_s1_a;
   logic [BITS_DATA-1:0] r_s1_b;
   logic [BITS_OP-1:0]   r_s1_op;

   logic                 r_s2_valid;
   logic [BITS_DATA-1:0] r_s2_result;
   logic                 r_s2_zero;
   logic                 r_s2_neg;
   logic                 r_s2_carry;
   logic                 r_s2_ovf;
   logic                 r_s2_err;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic [BITS_DATA:0]   w_sum;
   logic [BITS_DATA:0]   w_diff;
   logic                 w_shift_big;
   logic [BITS_DATA-1:0] w_result;
   logic                 w_carry;
   logic                 w_ovf;
   logic                 w_err;
   logic                 w_zero;
   logic                 w_neg;

   // A stage may load while its current content is leaving, so a full
   // pipeline streams one result per cycle when the sink is ready.
   assign w_s2_adv    = ~r_s2_valid | bus.i_ready;
   assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
   assign bus.o_ready = w_s1_adv;

   always_comb begin
      // Extra MSB of the unsigned sum/difference is carry-out / borrow.
      w_sum       = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      w_diff      = {1'b0, r_s1_a} - {1'b0, r_s1_b};
      w_shift_big = (r_s1_b >= LP_WIDTH);
      w_result    = '0;
      w_carry     = 1'b0;
      w_ovf       = 1'b0;
      w_err       = 1'b0;
      case (r_s1_op)
         LP_OP_ADD: begin
            w_result = w_sum[MSB:0];
            w_carry  = w_sum[BITS_DATA];
            w_ovf    = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
         end
         LP_OP_SUB: begin
            w_result = w_diff[MSB:0];
            w_carry  = w_diff[BITS_DATA];
            w_ovf    = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
         end
         LP_OP_AND: w_result = r_s1_a & r_s1_b;
         LP_OP_OR:  w_result = r_s1_a | r_s1_b;
         LP_OP_XOR: w_result = r_s1_a ^ r_s1_b;
         LP_OP_NOR: w_result = ~(r_s1_a | r_s1_b);
         LP_OP_SRL: w_result = w_shift_big ? '0 : (r_s1_a >> r_s1_b);
         LP_OP_SRA: w_result = w_shift_big ? {BITS_DATA{r_s1_a[MSB]}}
                                           : BITS_DATA'($signed(r_s1_a) >>> r_s1_b);
         default:   w_err = 1'b1;
      endcase
`ifdef ALU_PIPE_SAT_EN
      // Overflow direction follows A's sign for both ADD and SUB.
      if (w_ovf) w_result = r_s1_a[MSB] ? LP_SMIN : LP_SMAX;
`endif
   end

   assign w_zero = (w_result == '0);
   assign w_neg  = w_result[MSB];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_op     <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_zero   <= 1'b0;
         r_s2_neg    <= 1'b0;
         r_s2_carry  <= 1'b0;
         r_s2_ovf    <= 1'b0;
         r_s2_err    <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= bus.i_valid;
            r_s1_a     <= bus.i_a;
            r_s1_b     <= bus.i_b;
            r_s1_op    <= bus.i_op;
         end
         if (w_s2_adv) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_result <= w_result;
            r_s2_zero   <= w_zero;
            r_s2_neg    <= w_neg;
            r_s2_carry  <= w_carry;
            r_s2_ovf    <= w_ovf;
            r_s2_err    <= w_err;
         end
      end
   end

   assign bus.o_valid  = r_s2_valid;
   assign bus.o_result = r_s2_result;
   assign bus.o_zero   = r_s2_zero;
   assign bus.o_neg    = r_s2_neg;
   assign bus.o_carry  = r_s2_carry;
   assign bus.o_ovf    = r_s2_ovf;
   assign bus.o_err    = r_s2_err;
endmodule
